// File: rtl/pat_deadtime_ctrl_pkg.sv
// Shared pattern-field widths and helpers for the pattern dead-time controller.
// Field widths are owned here so the selector and this block always agree.
package pat_deadtime_ctrl_pkg;

  localparam int MXPATB     = 7;   // [6:4] layer-hit count, [3:0] pattern id
  localparam int MXKEYBX    = 8;   // [7:5] group, [4:0] half-strip in group
  localparam int MXSUBKEYBX = 10;
  localparam int MXQLTB     = 9;

  localparam int NGRP   = 7;
  localparam int CNTW   = 4;
  localparam int HS_MAX = 31;

  typedef struct packed {
    logic                  vld;
    logic [MXPATB-1:0]     pat;
    logic [MXKEYBX-1:0]    key;
    logic [MXSUBKEYBX-1:0] subkey;
    logic [MXQLTB-1:0]     qlt;
  } clct_t;

  // Groups whose dead-time counter is (re)loaded by an accept in group grp.
  // Neighbours are only marked near a group edge and never wrap past 0 or 6.
  function automatic logic [NGRP-1:0] grp_load_mask(input logic [2:0] grp,
                                                    input logic [4:0] hs,
                                                    input int         spread);
    logic [NGRP-1:0] m;
    m = '0;
    for (int i = 0; i < NGRP; i++) begin
      if (int'(grp) == i)
        m[i] = 1'b1;
      if ((int'(grp) == i + 1) && (int'(hs) < spread))
        m[i] = 1'b1;
      if ((int'(grp) == i - 1) && (int'(hs) > HS_MAX - spread))
        m[i] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/pat_deadtime_ctrl_cnt.sv
// Per-group dead-time down-counter; busy while the count is non-zero.
module dead_cnt
  import pat_deadtime_ctrl_pkg::*;
#(
  parameter int W = CNTW
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         load,
  input  logic         flush,
  input  logic [W-1:0] reload,
  output logic         busy
);

  logic [W-1:0] r_cnt;

  // flush beats load; load beats the decrement so re-acceptance restarts the window
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)
      r_cnt <= '0;
    else if (flush)
      r_cnt <= '0;
    else if (load)
      r_cnt <= reload;
    else if (r_cnt != '0)
      r_cnt <= r_cnt - W'(1);
  end

  assign busy = (r_cnt != '0);

endmodule

// File: rtl/pat_deadtime_ctrl.sv
// Accepts the selector's best pattern, registers it out, and holds the hit group
// (plus edge neighbours) busy for DEAD_CYCLES clocks so the selector skips them.
module pat_deadtime_ctrl
  import pat_deadtime_ctrl_pkg::*;
#(
  parameter int DEAD_CYCLES = 4,
  parameter int EDGE_SPREAD = 2,
  parameter int HIT_THRESH  = 4
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  enable,
  input  logic                  flush,
  input  logic [MXPATB-1:0]     best_pat,
  input  logic [MXKEYBX-1:0]    best_key,
  input  logic [MXSUBKEYBX-1:0] best_subkey,
  input  logic [MXQLTB-1:0]     best_qlt,
  input  logic                  best_bsy,
  output logic [NGRP-1:0]       bsy,
  output logic                  clct_vld,
  output logic [MXPATB-1:0]     clct_pat,
  output logic [MXKEYBX-1:0]    clct_key,
  output logic [MXSUBKEYBX-1:0] clct_subkey,
  output logic [MXQLTB-1:0]     clct_qlt,
  output logic [15:0]           accept_cnt,
  output logic                  bad_key
);

  localparam logic [CNTW-1:0] LP_DEAD = CNTW'(DEAD_CYCLES);

  logic [2:0]      w_grp;
  logic [4:0]      w_hs;
  logic [2:0]      w_hits;
  logic            w_thr_ok;
  logic            w_grp_ok;
  logic            w_accept;
  logic [NGRP-1:0] w_load;
  logic [NGRP-1:0] w_busy;

  clct_t           r_clct;
  logic [15:0]     r_acnt;
  logic            r_bad_key;

  assign w_grp    = best_key[7:5];
  assign w_hs     = best_key[4:0];
  assign w_hits   = best_pat[6:4];
  assign w_thr_ok = (int'(w_hits) >= HIT_THRESH);
  assign w_grp_ok = (w_grp != 3'd7);
  assign w_accept = enable && !flush && !best_bsy && w_thr_ok && w_grp_ok;
  assign w_load   = w_accept ? grp_load_mask(w_grp, w_hs, EDGE_SPREAD) : '0;

  for (genvar gi = 0; gi < NGRP; gi++) begin : g_grp
    dead_cnt #(.W(CNTW)) u_cnt (
      .clock   (clock),
      .reset_n (reset_n),
      .load    (w_load[gi]),
      .flush   (flush),
      .reload  (LP_DEAD),
      .busy    (w_busy[gi])
    );
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_clct    <= '0;
      r_acnt    <= '0;
      r_bad_key <= 1'b0;
    end else begin
      r_bad_key <= (w_grp == 3'd7);
      if (w_accept) begin
        r_clct.vld    <= 1'b1;
        r_clct.pat    <= best_pat;
        r_clct.key    <= best_key;
        r_clct.subkey <= best_subkey;
        r_clct.qlt    <= best_qlt;
        if (r_acnt != 16'hFFFF)
          r_acnt <= r_acnt + 16'd1;
      end else begin
        r_clct <= '0;
      end
    end
  end

  assign bsy         = w_busy;
  assign clct_vld    = r_clct.vld;
  assign clct_pat    = r_clct.pat;
  assign clct_key    = r_clct.key;
  assign clct_subkey = r_clct.subkey;
  assign clct_qlt    = r_clct.qlt;
  assign accept_cnt  = r_acnt;
  assign bad_key     = r_bad_key;

endmodule

// File: doc/pat_deadtime_ctrl.md
PAT_DEADTIME_CTRL -- requirements
Module: pat_deadtime_ctrl

Interface
REQ-001 The block SHALL have parameter DEAD_CYCLES, default 4, meaning the number of clocks a group stays busy after an accepted pattern (0 to 15; 0 disables busy).
REQ-002 The block SHALL have parameter EDGE_SPREAD, default 2, meaning the number of half-strips from a group edge within which the adjacent group is also made busy (0 to 15).
REQ-003 The block SHALL have parameter HIT_THRESH, default 4, meaning the minimum layer-hit count in best_pat[6:4] needed for acceptance.
REQ-004 Port: clock  in  1  single clock for all state.
REQ-005 Port: reset_n  in  1  asynchronous active-low reset.
REQ-006 Port: enable  in  1  acceptance enable, sampled each clock.
REQ-007 Port: flush  in  1  synchronous clear of all dead-time counters.
REQ-008 Port: best_pat  in  MXPATB  winning pattern from the 1-of-7 selector.
REQ-009 Port: best_key  in  MXKEYBX  winning key: [7:5] is the group, [4:0] is the half-strip within the group.
REQ-010 Port: best_subkey  in  MXSUBKEYBX  winning sub-key.
REQ-011 Port: best_qlt  in  MXQLTB  winning quality.
REQ-012 Port: best_bsy  in  1  selector found no non-busy candidate.
REQ-013 Port: bsy  out  7  per-group busy flags fed back to the selector's bsy0..bsy6.
REQ-014 Port: clct_vld  out  1  registered accepted-pattern strobe.
REQ-015 Port: clct_pat, clct_key, clct_subkey, clct_qlt  out  same widths as the corresponding best_* inputs  registered accepted fields.
REQ-016 Port: accept_cnt  out  16  saturating count of accepted patterns.
REQ-017 Port: bad_key  out  1  registered strobe, high for one cycle when best_key[7:5] > 6.

Function
REQ-018 The block SHALL compute accept = enable && !flush && !best_bsy && (best_pat[6:4] >= HIT_THRESH) && (best_key[7:5] <= 6), combinationally from the current inputs.
REQ-019 When accept is high, the block SHALL set clct_vld=1 on the next clock edge and load the clct_* outputs from the best_* inputs.
REQ-020 When accept is low, the block SHALL set clct_vld=0 on the next edge and clear all clct_* fields to 0; the latency is therefore exactly 1 clock.
REQ-021 Each group i (0 to 6) SHALL own a 4-bit down-counter cnt[i], and bsy[i] SHALL equal (cnt[i] != 0), decoded from registers only with no combinational path from the inputs.
REQ-022 When accept is high, the block SHALL load cnt[g] with DEAD_CYCLES, where g = best_key[7:5].
REQ-023 When accept is high, key[4:0] < EDGE_SPREAD and g > 0, the block SHALL also load cnt[g-1] with DEAD_CYCLES.
REQ-024 When accept is high, key[4:0] > 31-EDGE_SPREAD and g < 6, the block SHALL also load cnt[g+1] with DEAD_CYCLES.
REQ-025 A load SHALL override a decrement in the same cycle, so re-acceptance restarts the window.
REQ-026 Counters not loaded in a cycle SHALL decrement by 1 and hold at 0; busy therefore lasts exactly DEAD_CYCLES clocks, starting the cycle clct_vld rises.
REQ-027 When flush is high, the block SHALL clear every cnt to 0 on the next edge, and flush SHALL win over a simultaneous accept (the accept is suppressed per REQ-018).
REQ-028 The block SHALL increment accept_cnt on each accept and saturate it at 0xFFFF with no wrap-around.
REQ-029 When best_key[7:5] == 7 with all other acceptance terms true, the block SHALL reject the pattern, assert bad_key for 1 cycle and load no counter.
REQ-030 When DEAD_CYCLES == 0, bsy SHALL remain all zeros.

Reset
REQ-031 While reset_n is low, the block SHALL asynchronously force cnt=0, bsy=0, clct_vld=0, all clct_* fields=0, accept_cnt=0 and bad_key=0.
REQ-032 If reset_n is asserted in the middle of a dead-time window, the block SHALL abort the window, with bsy=0 on the first clock after reset_n is released.

Structure
REQ-033 MXPATB, MXKEYBX, MXSUBKEYBX and MXQLTB SHALL come from the shared pattern parameter package, and the block SHALL declare no local copies of them.
REQ-034 The per-group counter SHALL be implemented as sub-module dead_cnt (ports: load, flush, reload value, busy), instantiated 7 times.

Verification
REQ-035 The bench SHALL cover: best_pat=7'h70, key=8'h4A (g=2, hs=10), DEAD=4 -> clct_vld at cycle+1, bsy=7'b0000100 for exactly 4 cycles, accept_cnt=1.
REQ-036 The bench SHALL cover: key=8'h21 (g=1, hs=1), SPREAD=2 -> bsy=7'b0000011.
REQ-037 The bench SHALL cover: key=8'hDF (g=6, hs=31) -> bsy=7'b1000000 only, with no wrap to group 0.
REQ-038 The bench SHALL cover: pattern accepted in g=3, then again 2 cycles later -> cnt[3] reloads to 4 and bsy[3] stays high 6 cycles total.
REQ-039 The bench SHALL cover: flush together with a valid pattern -> clct_vld=0 and bsy=0 next cycle; best_bsy=1 -> no accept; best_pat[6:4]=3 -> no accept.
REQ-040 The bench SHALL cover: key=8'hE0 -> bad_key pulses once with no busy; reset_n pulsed low mid-window -> all outputs 0 immediately; 70000 accepts -> accept_cnt=0xFFFF.
